// File: rtl/sram_bist_pkg.sv
// rtl/sram_bist_pkg.sv - shared state, mode and LFSR definitions for the SRAM BIST controller
package sram_bist_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CRST,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_WR_ADV,
    ST_SWITCH,
    ST_RD_SETTLE,
    ST_RD_CMP,
    ST_RD_ADV,
    ST_DONE
  } bist_state_t;

  localparam logic [1:0] MODE_PRNG     = 2'd0;
  localparam logic [1:0] MODE_ADDR     = 2'd1;
  localparam logic [1:0] MODE_CHECKER  = 2'd2;
  localparam logic [1:0] MODE_INV_PRNG = 2'd3;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  // An all-zero seed would lock the LFSR, so it is swapped for this value
  localparam logic [15:0] ZERO_SEED_SUB = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/sram_bist_pattern_gen.sv
// rtl/sram_bist_pattern_gen.sv - LFSR and pattern mux producing the word for the current index
module sram_bist_pattern_gen
  import sram_bist_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load,
  input  logic [15:0]       seed,
  input  logic              step,
  input  logic              invert,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] idx,
  output logic [DATA_W-1:0] pattern
);

  localparam logic [DATA_W-1:0] CHK_EVEN = DATA_W'({8{2'b01}});
  localparam logic [DATA_W-1:0] CHK_ODD  = DATA_W'({8{2'b10}});

  logic [15:0]       lfsr_q;
  logic [DATA_W-1:0] base;

  // LFSR reloads from the seed at the start of each phase and steps once per word
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lfsr_q <= ZERO_SEED_SUB;
    end else if (load) begin
      lfsr_q <= seed;
    end else if (step) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  // Select the base pattern by mode; the inverted pass flips every bit
  always_comb begin
    base = lfsr_q[DATA_W-1:0];
    case (mode)
      MODE_ADDR:     base = DATA_W'(idx);
      MODE_CHECKER:  base = idx[0] ? CHK_ODD : CHK_EVEN;
      MODE_INV_PRNG: base = ~lfsr_q[DATA_W-1:0];
      default:       base = lfsr_q[DATA_W-1:0];
    endcase
    pattern = base ^ {DATA_W{invert}};
  end

endmodule

// File: rtl/sram_bist_ctrl.sv
// rtl/sram_bist_ctrl.sv - SRAM BIST controller top; SRAM_BIST_INV_PASS_EN adds an inverted second pass
module sram_bist_ctrl
  import sram_bist_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int SETUP_CYC = 8,
  parameter int WE_CYC    = 4,
  parameter int HOLD_CYC  = 500
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [1:0]        MODE,
  input  logic [15:0]       SEED,
  output logic              COUNTER_CLK,
  output logic              COUNTER_RST,
  output logic              WE_BAR,
  inout  wire  [DATA_W-1:0] SRAM_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
`ifdef SRAM_BIST_INV_PASS_EN
  output logic [ADDR_W+1:0] ERR_COUNT,
`else
  output logic [ADDR_W:0]   ERR_COUNT,
`endif
  output logic              FAIL_VALID,
  output logic [ADDR_W-1:0] FAIL_ADDR
);

`ifdef SRAM_BIST_INV_PASS_EN
  localparam int ERR_W = ADDR_W + 2;
  localparam int NPASS = 2;
`else
  localparam int ERR_W = ADDR_W + 1;
  localparam int NPASS = 1;
`endif

  localparam int MAX_WAIT = (HOLD_CYC > SETUP_CYC) ? ((HOLD_CYC > WE_CYC) ? HOLD_CYC : WE_CYC)
                                                   : ((SETUP_CYC > WE_CYC) ? SETUP_CYC : WE_CYC);
  localparam int TMR_W = $clog2(2 * MAX_WAIT + 1);
  typedef logic [TMR_W-1:0] tmr_t;

  localparam tmr_t T_HOLD2 = tmr_t'(2 * HOLD_CYC - 1);
  localparam tmr_t T_HOLD  = tmr_t'(HOLD_CYC);
  localparam tmr_t T_SETUP = tmr_t'(SETUP_CYC - 1);
  localparam tmr_t T_WE    = tmr_t'(WE_CYC - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX  = ERR_W'(NPASS * DEPTH);

  bist_state_t       state_q, state_d;
  tmr_t              tmr_q, tmr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              inv_q, inv_d;
  logic [15:0]       seed_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] rd_q, pattern;
  logic [ERR_W-1:0]  err_q;
  logic              fv_q;
  logic [ADDR_W-1:0] fa_q;
  logic              start_go, step, capture, cmp;
  logic              cclk_q, crst_q, we_bar_q, drv_q, busy_q, done_q;

  sram_bist_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_pat (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .load   ((state_q == ST_CRST) || (state_q == ST_SWITCH)),
    .seed   (seed_q),
    .step   (step),
    .invert (inv_q),
    .mode   (mode_q),
    .idx    (idx_q),
    .pattern(pattern)
  );

  // Next-state logic; every wait runs on the shared down-timer reloaded at each transition
  always_comb begin
    state_d  = state_q;
    tmr_d    = (tmr_q != '0) ? tmr_q - 1'b1 : '0;
    idx_d    = idx_q;
    inv_d    = inv_q;
    start_go = 1'b0;
    step     = 1'b0;
    capture  = 1'b0;
    cmp      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: if (START) begin
        state_d  = ST_CRST;
        tmr_d    = T_HOLD2;
        start_go = 1'b1;
        inv_d    = 1'b0;
      end
      ST_CRST: if (tmr_q == '0) begin
        state_d = ST_WR_SETUP;
        tmr_d   = T_SETUP;
        idx_d   = '0;
      end
      ST_WR_SETUP: if (tmr_q == '0) begin
        state_d = ST_WR_PULSE;
        tmr_d   = T_WE;
      end
      ST_WR_PULSE: if (tmr_q == '0) state_d = ST_WR_HOLD;
      ST_WR_HOLD: begin
        state_d = (idx_q == LAST_IDX) ? ST_SWITCH : ST_WR_ADV;
        tmr_d   = T_HOLD2;
      end
      ST_WR_ADV: if (tmr_q == '0) begin
        state_d = ST_WR_SETUP;
        tmr_d   = T_SETUP;
        idx_d   = idx_q + 1'b1;
        step    = 1'b1;
      end
      ST_SWITCH: if (tmr_q == '0) begin
        state_d = ST_RD_SETTLE;
        tmr_d   = T_SETUP;
        idx_d   = '0;
      end
      ST_RD_SETTLE: if (tmr_q == '0) begin
        state_d = ST_RD_CMP;
        capture = 1'b1;
      end
      ST_RD_CMP: begin
        cmp = 1'b1;
        if (idx_q == LAST_IDX) begin
`ifdef SRAM_BIST_INV_PASS_EN
          if (!inv_q) begin
            state_d = ST_CRST;
            tmr_d   = T_HOLD2;
            inv_d   = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_RD_ADV;
          tmr_d   = T_HOLD2;
        end
      end
      ST_RD_ADV: if (tmr_q == '0) begin
        state_d = ST_RD_SETTLE;
        tmr_d   = T_SETUP;
        idx_d   = idx_q + 1'b1;
        step    = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, timer, index and registered pin outputs (derived from next state so pins are glitch-free)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      idx_q    <= '0;
      inv_q    <= 1'b0;
      cclk_q   <= 1'b1;
      crst_q   <= 1'b0;
      we_bar_q <= 1'b1;
      drv_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      idx_q    <= idx_d;
      inv_q    <= inv_d;
      cclk_q   <= !(((state_d == ST_WR_ADV) || (state_d == ST_RD_ADV)) && (tmr_d >= T_HOLD));
      crst_q   <= ((state_d == ST_CRST) || (state_d == ST_SWITCH)) && (tmr_d >= T_HOLD);
      we_bar_q <= (state_d != ST_WR_PULSE);
      drv_q    <= state_d inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD};
      busy_q   <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_q   <= (state_d == ST_DONE);
    end
  end

  // Test configuration latch, read capture and error statistics
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seed_q <= ZERO_SEED_SUB;
      mode_q <= MODE_PRNG;
      rd_q   <= '0;
      err_q  <= '0;
      fv_q   <= 1'b0;
      fa_q   <= '0;
    end else begin
      if (capture) rd_q <= SRAM_DATA;
      if (start_go) begin
        seed_q <= (SEED == 16'h0000) ? ZERO_SEED_SUB : SEED;
        mode_q <= MODE;
        err_q  <= '0;
        fv_q   <= 1'b0;
        fa_q   <= '0;
      end else if (cmp && (rd_q != pattern)) begin
        if (err_q != ERR_MAX) err_q <= err_q + 1'b1;
        if (!fv_q) begin
          fv_q <= 1'b1;
          fa_q <= idx_q;
        end
      end
    end
  end

  assign SRAM_DATA   = drv_q ? pattern : {DATA_W{1'bz}};
  assign COUNTER_CLK = cclk_q;
  assign COUNTER_RST = crst_q;
  assign WE_BAR      = we_bar_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign PASS        = done_q && (err_q == '0);
  assign ERR_COUNT   = err_q;
  assign FAIL_VALID  = fv_q;
  assign FAIL_ADDR   = fa_q;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// tb/tb_sram_bist_ctrl.sv - table-driven bench with behavioural SRAM, ripple counter and protocol monitor
module tb_sram_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] seed = 16'h0000;
  logic        counter_clk, counter_rst, we_bar, busy, done, pass, fail_valid;
  logic [4:0]  err_count;
  logic [3:0]  fail_addr;
  wire  [7:0]  sram_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_bist_ctrl #(
    .DATA_W(8), .DEPTH(16), .ADDR_W(4), .SETUP_CYC(8), .WE_CYC(4), .HOLD_CYC(4)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .MODE(mode), .SEED(seed),
    .COUNTER_CLK(counter_clk), .COUNTER_RST(counter_rst), .WE_BAR(we_bar),
    .SRAM_DATA(sram_data), .BUSY(busy), .DONE(done), .PASS(pass),
    .ERR_COUNT(err_count), .FAIL_VALID(fail_valid), .FAIL_ADDR(fail_addr)
  );

  pullup (sram_data);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Behavioural SRAM + MC14040-style counter; fault 1 = bit 3 stuck at 0, fault 2 = word 5 reads back corrupted
  logic [7:0] mem [16];
  logic [3:0] addr = 4'd0;
  int         fault = 0;
  logic       rd_phase = 1'b0;
  logic       wrote = 1'b0;
  int         fall_cnt = 0;
  int         phase_cnt = 0;
  logic       prev_cclk = 1'b1;
  logic       model_oe;
  logic [7:0] rd_val;

  assign rd_val    = mem[addr] ^ (((fault == 2) && (addr == 4'd5)) ? 8'h01 : 8'h00);
  assign model_oe  = rd_phase && we_bar && counter_clk && !counter_rst && rst_n;
  assign sram_data = model_oe ? rd_val : 8'hzz;

  always @(negedge counter_clk or posedge counter_rst) begin
    if (counter_rst) addr <= 4'd0;
    else             addr <= addr + 4'd1;
  end

  always @(negedge counter_clk) if (!counter_rst) fall_cnt++;

  always @(negedge we_bar) if (rst_n) wrote = 1'b1;

  always @(posedge we_bar) begin
    if (rst_n) mem[addr] = (fault == 1) ? (sram_data & 8'hF7) : sram_data;
  end

  always @(negedge rst_n) begin
    wrote     = 1'b0;
    rd_phase  = 1'b0;
    phase_cnt = 0;
  end

  always @(posedge counter_rst) begin
    rd_phase = wrote;
    wrote    = 1'b0;
    if (phase_cnt > 0) check("falls_per_write_phase", fall_cnt, 15);
    phase_cnt++;
    fall_cnt = 0;
  end

  always @(posedge done) begin
    check("falls_per_read_phase", fall_cnt, 15);
    phase_cnt = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("we_low_while_counter_active",
            int'(!we_bar && ((counter_clk != prev_cclk) || counter_rst)), 0);
      if (!model_oe && (!counter_clk || counter_rst || !busy))
        check("bus_released", int'(sram_data), 8'hFF);
    end
    prev_cclk = counter_clk;
  end

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] seed;
    int          fault;
    int          exp_err;
    int          exp_fv;
    int          exp_fa;
    int          exp_pass;
    int          exp_m0;
    int          exp_m1;
  } vec_t;

  vec_t vecs[5];

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'hC3;
  endtask

  task automatic run_test(input logic [1:0] m, input logic [15:0] s, input bit hold,
                          output int busy_cyc, output int timed_out);
    @(negedge clk);
    mode  = m;
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = hold;
    busy_cyc = 0;
    for (int n = 0; n < 3000 && !done; n++) begin
      if (busy) busy_cyc++;
      @(negedge clk);
    end
    timed_out = int'(!done);
  endtask

  task automatic check_result(input string tag, input vec_t v, input int busy_cyc, input int timed_out);
    check({tag, "_timeout"}, timed_out, 0);
    check({tag, "_busy_cycles"}, busy_cyc, 608);
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_pass"}, int'(pass), v.exp_pass);
    check({tag, "_err_count"}, int'(err_count), v.exp_err);
    check({tag, "_fail_valid"}, int'(fail_valid), v.exp_fv);
    check({tag, "_fail_addr"}, int'(fail_addr), v.exp_fa);
    check({tag, "_mem0"}, int'(mem[0]), v.exp_m0);
    check({tag, "_mem1"}, int'(mem[1]), v.exp_m1);
  endtask

  initial begin
    int   bc, to;
    vec_t good;

    vecs[0] = '{2'd0, 16'h1234, 0, 0, 0, 0, 1, 8'h34, 8'h1A};
    vecs[1] = '{2'd1, 16'h1234, 1, 8, 1, 8, 0, 8'h00, 8'h01};
    vecs[2] = '{2'd2, 16'h1234, 2, 1, 1, 5, 0, 8'h55, 8'hAA};
    vecs[3] = '{2'd0, 16'h0000, 0, 0, 0, 0, 1, 8'hE1, 8'h70};
    vecs[4] = '{2'd3, 16'hBEEF, 0, 0, 0, 0, 1, 8'h10, 8'h88};
    good    = vecs[0];

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_counter_clk", int'(counter_clk), 1);
    check("rst_counter_rst", int'(counter_rst), 0);
    check("rst_we_bar", int'(we_bar), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_fail_valid", int'(fail_valid), 0);
    check("rst_fail_addr", int'(fail_addr), 0);
    check("rst_bus_z", int'(sram_data), 8'hFF);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      fault = vecs[i].fault;
      clear_mem();
      run_test(vecs[i].mode, vecs[i].seed, 1'b0, bc, to);
      check_result($sformatf("vec%0d", i), vecs[i], bc, to);
    end

    // Reset while word 7 is being written, then a clean restart
    fault = 0;
    clear_mem();
    @(negedge clk);
    mode  = 2'd0;
    seed  = 16'h1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to = 1;
    for (int n = 0; n < 3000; n++) begin
      if ((addr == 4'd7) && !we_bar) begin
        to = 0;
        break;
      end
      @(negedge clk);
    end
    check("midrst_reached_word7", to, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_counter_clk", int'(counter_clk), 1);
    check("midrst_counter_rst", int'(counter_rst), 0);
    check("midrst_we_bar", int'(we_bar), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_bus_z", int'(sram_data), 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    clear_mem();
    run_test(2'd0, 16'h1234, 1'b0, bc, to);
    check_result("restart", good, bc, to);

    // START held through BUSY and into DONE: first run completes untouched, DONE relaunches with stats cleared
    fault = 1;
    clear_mem();
    run_test(2'd1, 16'h1234, 1'b1, bc, to);
    check_result("held", vecs[1], bc, to);
    fault = 0;
    @(negedge clk);
    check("held_restart_done", int'(done), 0);
    check("held_restart_busy", int'(busy), 1);
    check("held_restart_err", int'(err_count), 0);
    check("held_restart_fv", int'(fail_valid), 0);
    start = 1'b0;
    to = 1;
    for (int n = 0; n < 3000; n++) begin
      if (done) begin
        to = 0;
        break;
      end
      @(negedge clk);
    end
    check("held_second_timeout", to, 0);
    check("held_second_pass", int'(pass), 1);
    check("held_second_err", int'(err_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_bist_ctrl.md
Name: sram_bist_ctrl

Overview:
Parametrised built-in self-test controller for external async SRAM chips addressed by an external ripple counter (MC14040-class).
- Write phase: writes DEPTH words of a selectable pattern.
- Read phase: resets the counter, reads the words back and compares them on the fly.
- Reports pass/fail, error count and first failing address.
- Regenerates the expected data from the seed instead of storing it, so area does not grow with DEPTH.

Parameters:
DATA_W, 8, total SRAM data width across all chips (1..16).
DEPTH, 16, number of words tested (power of 2, at least 2).
ADDR_W, 4, log2(DEPTH).
SETUP_CYC, 8, cycles data/address settle before WE low or before the read sample.
WE_CYC, 4, WE_BAR low width in cycles.
HOLD_CYC, 500, COUNTER_CLK low and high time, and COUNTER_RST pulse width, in cycles.

Ports:
CLK  in  1  system clock.
RST_N  in  1  asynchronous active-low reset.
START  in  1  begin a test; sampled only in IDLE.
MODE  in  2  pattern: 0 PRNG, 1 address-as-data, 2 checkerboard (0x55.. / 0xAA.. alternating), 3 inverted PRNG.
SEED  in  16  LFSR seed, latched on START.
COUNTER_CLK  out  1  external address counter clock; counter advances on the falling edge.
COUNTER_RST  out  1  external counter reset, active-high.
WE_BAR  out  1  SRAM write enable, active-low.
SRAM_DATA  inout  DATA_W  SRAM data bus; driven only in the write states, else high-Z.
BUSY  out  1  test in progress.
DONE  out  1  test finished; held until the next START.
PASS  out  1  DONE and ERR_COUNT==0.
ERR_COUNT  out  ADDR_W+1  number of mismatching words.
FAIL_VALID  out  1  at least one mismatch recorded.
FAIL_ADDR  out  ADDR_W  index of the first mismatching word.

Behaviour:
- Reset (async, immediate) values:
  - COUNTER_CLK=1, COUNTER_RST=0, WE_BAR=1, SRAM_DATA=Z.
  - BUSY, DONE, PASS, FAIL_VALID, ERR_COUNT, FAIL_ADDR = 0; FSM in IDLE.
  - Reset mid-test abandons the test; there is no resume.
- FSM states: IDLE, CRST, WR_SETUP, WR_PULSE, WR_HOLD, WR_ADV, SWITCH, RD_SETTLE, RD_CMP, RD_ADV, DONE. A single down-timer sized for max(HOLD_CYC, SETUP_CYC)*2 drives all waits. Word index idx is ADDR_W bits.
- IDLE:
  - START=1 latches SEED and MODE, clears the stats, sets BUSY, goes to CRST.
  - SEED==0 is replaced by 16'hACE1.
- CRST: COUNTER_RST=1 for HOLD_CYC cycles, then 0 for HOLD_CYC cycles; idx=0 -> WR_SETUP.
- WR_SETUP: SRAM_DATA driven with pattern(idx); WE_BAR=1 for SETUP_CYC cycles -> WR_PULSE.
- WR_PULSE: WE_BAR=0 for WE_CYC cycles -> WR_HOLD.
- WR_HOLD: one cycle, WE_BAR=1, data still driven. If idx==DEPTH-1 -> SWITCH, else -> WR_ADV.
- WR_ADV:
  - SRAM_DATA is Z and WE_BAR=1 throughout; WE_BAR is never low while COUNTER_CLK toggles.
  - COUNTER_CLK=0 for HOLD_CYC cycles, then 1 for HOLD_CYC cycles; idx++ and LFSR steps -> WR_SETUP.
- SWITCH: same COUNTER_RST pulse as CRST; LFSR reloads from the latched seed; idx=0 -> RD_SETTLE.
- RD_SETTLE: WE_BAR=1 for SETUP_CYC cycles; SRAM_DATA is registered on the last cycle.
- RD_CMP (one cycle):
  - Compare the registered read value with pattern(idx).
  - On mismatch: ERR_COUNT++; if FAIL_VALID==0, set FAIL_VALID=1 and FAIL_ADDR=idx.
  - If idx==DEPTH-1 -> DONE, else -> RD_ADV.
- RD_ADV: same as WR_ADV -> RD_SETTLE.
- DONE: BUSY=0, DONE=1, PASS=(ERR_COUNT==0). START returns to the IDLE start path and clears DONE.
- START while BUSY is ignored.
- Patterns:
  - PRNG is the low DATA_W bits of a 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, stepped once per word.
  - Address mode is idx zero-extended or truncated to DATA_W.
  - Checkerboard uses idx[0] to select 0x55../0xAA...
- ERR_COUNT saturates at DEPTH; it cannot exceed DEPTH by construction.

Optional Feature:
SRAM_BIST_INV_PASS_EN
- Defined: after the first read phase the FSM runs a second full write+read pass with every pattern word bitwise inverted, starting from the same seed. Errors from both passes accumulate. FAIL_ADDR reports the first failure overall. ERR_COUNT widens to ADDR_W+2 and saturates at 2*DEPTH.
- Undefined: single pass only; ERR_COUNT stays ADDR_W+1 wide.

Decomposition:
- Package sram_bist_pkg holds:
  - FSM state encoding.
  - MODE codes.
  - LFSR taps constant and the zero-seed replacement constant.
- One sub-module, sram_bist_pattern_gen: LFSR plus mode mux. Inputs: load/step/invert/idx. Output: DATA_W pattern.

Test Plan:
- Bench uses a behavioural SRAM and counter model, DATA_W=8, DEPTH=16, HOLD_CYC=4.
- MODE=0, SEED=16'h1234, START -> 16 writes then 16 reads; DONE=1, PASS=1, ERR_COUNT=0, FAIL_VALID=0.
- MODE=1, model forces bit 3 stuck-at-0 -> ERR_COUNT=8 (idx 8..15), FAIL_ADDR=8, PASS=0.
- MODE=2, model corrupts word 5 only -> ERR_COUNT=1, FAIL_ADDR=5; SEED=0 run with MODE=0 uses 16'hACE1 and passes.
- Protocol checker across all runs:
  - WE_BAR never low while COUNTER_CLK changes or while COUNTER_RST=1.
  - SRAM_DATA is Z whenever WE_BAR=1 outside WR_SETUP/WR_HOLD.
  - Exactly 15 COUNTER_CLK falling edges per phase.
- RST_N pulsed low mid-write at word 7 -> all outputs at reset values in the same cycle; bus Z; a later START restarts from idx 0 and passes.
- START held high during BUSY and during DONE -> ignored while BUSY; a new test begins from DONE with stats cleared.
